// File: rtl/notgate_pipe_delay.sv
// Masked inverter with a fixed DELAY-stage, valid-tagged pipeline.
// Ports: clk, rst (sync, active-high), en (advance), flush (drop all),
//   in_valid/in_ready/in_data/in_mask (input sample),
//   out_valid/out_data (result, zero when not valid), in_flight (valid count).
module notgate_pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DELAY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           in_mask,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DELAY+1)-1:0] in_flight
);

    localparam int CW = $clog2(DELAY + 1);

    logic [DELAY-1:0] v;
    logic [WIDTH-1:0] d [DELAY];
    logic [CW-1:0]    cnt;
    logic             acc;
    logic             leave;

    assign in_ready = en & ~flush;
    assign acc      = in_valid & in_ready;
    // The output stage empties on every advancing edge.
    assign leave    = v[DELAY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            cnt <= '0;
            for (int k = 0; k < DELAY; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            // Data registers keep their contents; only validity is dropped.
            v   <= '0;
            cnt <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            d[0] <= in_data ^ in_mask;
            for (int k = 1; k < DELAY; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
            cnt <= cnt + CW'(acc) - CW'(leave);
        end
    end

    assign out_valid = v[DELAY-1];
    assign out_data  = v[DELAY-1] ? d[DELAY-1] : '0;
    assign in_flight = cnt;

endmodule

// File: tb/tb_notgate_pipe_delay.sv
// Bench for notgate_pipe_delay: DELAY=3 and DELAY=1 instances share stimulus
// and are compared with a queue-based model of in-flight samples.
module tb_notgate_pipe_delay;

    logic       clk = 0;
    logic       rst, en, flush, in_valid;
    logic [7:0] in_data, in_mask;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [1:0] in_flight;
    logic       in_ready1, out_valid1;
    logic [7:0] out_data1;
    logic [0:0] in_flight1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] d;
        int         age;
    } item_t;
    typedef item_t iq_t[$];

    iq_t q3, q1;
    bit         ev3, ev1;
    logic [7:0] ed3, ed1;
    int         ef3, ef1;
    logic       rdy, rdy1;

    always #5 clk = ~clk;

    notgate_pipe_delay #(.WIDTH(8), .DELAY(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_data(out_data),
        .in_flight(in_flight)
    );

    notgate_pipe_delay #(.WIDTH(8), .DELAY(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid1), .out_data(out_data1),
        .in_flight(in_flight1)
    );

    // Each item carries how many advancing edges it has seen since accept;
    // it is visible at the output once that reaches the latency.
    task automatic adv(input int dl, input iq_t qi, input bit r, e, f, iv,
                       input logic [7:0] x, output iq_t qo);
        item_t it;
        qo = qi;
        if (r || f) begin
            qo = {};
        end else if (e) begin
            qo = {};
            foreach (qi[i]) begin
                if (qi[i].age < dl) begin
                    it.d   = qi[i].d;
                    it.age = qi[i].age + 1;
                    qo.push_back(it);
                end
            end
            if (iv) begin
                it.d   = x;
                it.age = 1;
                qo.push_back(it);
            end
        end
    endtask

    task automatic expect_of(input int dl, input iq_t q, output bit ev,
                             output logic [7:0] ed, output int ef);
        ev = 0;
        ed = 8'h00;
        ef = q.size();
        foreach (q[i]) begin
            if (q[i].age == dl) begin
                ev = 1;
                ed = q[i].d;
            end
        end
    endtask

    task automatic step(input bit r, e, f, iv, input logic [7:0] dd, mm);
        iq_t n;
        rst = r; en = e; flush = f; in_valid = iv;
        in_data = dd; in_mask = mm;
        #1;
        rdy  = in_ready;
        rdy1 = in_ready1;
        @(posedge clk);
        adv(3, q3, r, e, f, iv, dd ^ mm, n);
        q3 = n;
        adv(1, q1, r, e, f, iv, dd ^ mm, n);
        q1 = n;
        #1;
        expect_of(3, q3, ev3, ed3, ef3);
        expect_of(1, q1, ev1, ed1, ef1);
    endtask

    task automatic test_reset;
        step(1, 1, 0, 1, 8'h12, 8'h34);
        step(1, 1, 0, 1, 8'h56, 8'h78);
        step(0, 1, 0, 0, 8'h00, 8'h00);
        tests++;
        if ({out_valid, out_data, in_flight} !== 11'h0) begin
            fails++;
            $display("FAIL reset3 got v=%0b d=%h f=%0d want 0",
                     out_valid, out_data, in_flight);
        end
        tests++;
        if ({out_valid1, out_data1, in_flight1} !== 10'h0) begin
            fails++;
            $display("FAIL reset1 got v=%0b d=%h f=%0d want 0",
                     out_valid1, out_data1, in_flight1);
        end
    endtask

    task automatic test_latency;
        logic [7:0] dv [5] = '{8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00};
        logic [7:0] mv [5] = '{8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00};
        bit         wv [5] = '{0, 0, 1, 1, 0};
        logic [7:0] wd [5] = '{8'h00, 8'h00, 8'h5A, 8'hFF, 8'h00};
        int         wf [5] = '{1, 2, 2, 1, 0};
        bit         wv1 [5] = '{1, 1, 0, 0, 0};
        logic [7:0] wd1 [5] = '{8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00};
        step(1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, i < 2, dv[i], mv[i]);
            tests++;
            if (out_valid !== wv[i] || out_data !== wd[i]
                || in_flight !== 2'(wf[i])) begin
                fails++;
                $display("FAIL lat3 c%0d got v=%0b d=%h f=%0d want %0b %h %0d",
                         i, out_valid, out_data, in_flight,
                         wv[i], wd[i], wf[i]);
            end
            tests++;
            if (out_valid1 !== wv1[i] || out_data1 !== wd1[i]) begin
                fails++;
                $display("FAIL lat1 c%0d got v=%0b d=%h want %0b %h",
                         i, out_valid1, out_data1, wv1[i], wd1[i]);
            end
        end
    endtask

    task automatic test_stall;
        step(1, 1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 1, 8'h01, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 8'($urandom), 8'($urandom));
            tests++;
            if (rdy !== 1'b0 || in_flight !== 2'd1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall s%0d got rdy=%0b f=%0d v=%0b want 0 1 0",
                         i, rdy, in_flight, out_valid);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 8'h00, 8'h00);
            tests++;
            if (out_valid !== (i == 1) || out_data !== (i == 1 ? 8'hFE : 8'h00)
                || in_flight !== 2'(ef3)) begin
                fails++;
                $display("FAIL resume r%0d got v=%0b d=%h f=%0d want %0b %h %0d",
                         i, out_valid, out_data, in_flight,
                         i == 1, i == 1 ? 8'hFE : 8'h00, ef3);
            end
        end
    endtask

    task automatic test_flush;
        step(1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 8'($urandom), 8'($urandom));
        end
        step(0, 1, 1, 1, 8'h33, 8'h0F);
        tests++;
        if (in_flight !== 2'd0 || out_valid !== 1'b0 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL flush got f=%0d v=%0b rdy=%0b want 0 0 0",
                     in_flight, out_valid, rdy);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 8'h00, 8'h00);
            tests++;
            if (out_valid !== 1'b0 || out_valid1 !== 1'b0
                || in_flight !== 2'd0) begin
                fails++;
                $display("FAIL postflush c%0d got v=%0b v1=%0b f=%0d want 0",
                         i, out_valid, out_valid1, in_flight);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        logic [7:0] w;
        logic [7:0] dd, mm;
        int         pulses = 0;
        step(1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 24; i++) begin
            dd = 8'($urandom);
            mm = 8'($urandom);
            if (i < 20) exp.push_back(dd ^ mm);
            step(0, 1, 0, i < 20, dd, mm);
            if (out_valid) begin
                pulses++;
                w = exp.size() > 0 ? exp.pop_front() : 8'hXX;
                tests++;
                if (out_data !== w) begin
                    fails++;
                    $display("FAIL b2b c%0d got %h want %h", i, out_data, w);
                end
            end
            if (i >= 2 && i < 20) begin
                tests++;
                if (in_flight !== 2'd3 || out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_steady c%0d got f=%0d v=%0b want 3 1",
                             i, in_flight, out_valid);
                end
            end
        end
        tests++;
        if (pulses != 20) begin
            fails++;
            $display("FAIL b2b_count got %0d want 20", pulses);
        end
    endtask

    task automatic test_reset_mid;
        step(1, 1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 1, 8'hC3, 8'h3C);
        step(0, 1, 0, 1, 8'h77, 8'h11);
        tests++;
        if (in_flight !== 2'd2) begin
            fails++;
            $display("FAIL midrst_pre got f=%0d want 2", in_flight);
        end
        step(1, 1, 0, 1, 8'hAA, 8'h55);
        tests++;
        if ({out_valid, out_data, in_flight} !== 11'h0
            || {out_valid1, out_data1, in_flight1} !== 10'h0) begin
            fails++;
            $display("FAIL midrst got v=%0b d=%h f=%0d v1=%0b want 0",
                     out_valid, out_data, in_flight, out_valid1);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 8'h00, 8'h00);
            tests++;
            if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin
                fails++;
                $display("FAIL stale c%0d got v=%0b v1=%0b want 0",
                         i, out_valid, out_valid1);
            end
        end
    endtask

    task automatic test_random;
        bit r, e, f, iv;
        step(1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(99) < 3);
            e  = ($urandom_range(99) < 75);
            f  = ($urandom_range(99) < 8);
            iv = ($urandom_range(99) < 70);
            step(r, e, f, iv, 8'($urandom), 8'($urandom));
            tests++;
            if (out_valid !== ev3 || out_data !== ed3
                || in_flight !== 2'(ef3) || rdy !== (e & ~f)) begin
                fails++;
                $display("FAIL rnd3 c%0d got v=%0b d=%h f=%0d r=%0b want %0b %h %0d %0b",
                         i, out_valid, out_data, in_flight, rdy,
                         ev3, ed3, ef3, e & ~f);
            end
            tests++;
            if (out_valid1 !== ev1 || out_data1 !== ed1
                || in_flight1 !== 1'(ef1) || rdy1 !== (e & ~f)) begin
                fails++;
                $display("FAIL rnd1 c%0d got v=%0b d=%h f=%0d want %0b %h %0d",
                         i, out_valid1, out_data1, in_flight1, ev1, ed1, ef1);
            end
        end
    endtask

    initial begin
        rst = 1; en = 0; flush = 0; in_valid = 0;
        in_data = 0; in_mask = 0;
        test_reset;
        test_latency;
        test_stall;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
